// File: rtl/dsp_host_port_pkg.sv
// Shared encodings for the DSP register-port host: command opcodes and FSM states.
package dsp_host_port_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_START = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RESP    = 3'd3,
    ST_START   = 3'd4
  } state_e;

  // Wide enough for RD_LAT-1 with RD_LAT up to 7.
  localparam int LAT_W = 3;

endpackage

// File: rtl/dsp_host_port_if.sv
// CPU-facing command and response streams of the DSP register-port host.
interface dsp_host_port_if
  import dsp_host_port_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 26
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/dsp_host_port_cmd_fifo.sv
// Synchronous command FIFO; registered count, head visible one cycle after the write.
module dsp_host_port_cmd_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dsp_host_port.sv
// Host initiator: queues CPU commands and sequences them onto the DSP block register port.
module dsp_host_port
  import dsp_host_port_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 26,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  dsp_host_port_if.slave    host,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              we,
  output logic              start_dec,
  input  logic [DATA_W-1:0] dout,
  output logic              busy
);

  localparam int CMD_W  = 2 + ADDR_W + DATA_W;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W-1:0] count_nxt;
  logic              push;
  logic              pop;

  op_e               head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  state_e            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              en_nxt, we_nxt, start_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;

  assign push           = host.cmd_valid && host.cmd_ready;
  assign host.cmd_ready = !fifo_full;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  assign head_op   = op_e'(fifo_head[CMD_W-1 -: 2]);
  assign head_addr = fifo_head[DATA_W +: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  dsp_host_port_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata ({host.cmd_op, host.cmd_addr, host.cmd_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned (latch).
  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    pop           = 1'b0;
    en_nxt        = 1'b0;
    we_nxt        = 1'b0;
    start_nxt     = 1'b0;
    addr_nxt      = addr;
    din_nxt       = din;
    rsp_valid_nxt = rsp_valid_q;
    rsp_data_nxt  = rsp_data_q;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_op)
            OP_WRITE: begin
              state_nxt = ST_WRITE;
              en_nxt    = 1'b1;
              we_nxt    = 1'b1;
              addr_nxt  = head_addr;
              din_nxt   = head_data;
            end
            OP_READ: begin
              state_nxt   = ST_RD_WAIT;
              en_nxt      = 1'b1;
              addr_nxt    = head_addr;
              lat_cnt_nxt = LAT_W'(RD_LAT - 1);
            end
            OP_START: begin
              state_nxt = ST_START;
              en_nxt    = 1'b1;
              start_nxt = 1'b1;
            end
            default: ;  // nop is consumed with no port activity
          endcase
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_RD_WAIT: begin
        if (lat_cnt == '0) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = dout;
          state_nxt     = ST_RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
          en_nxt      = 1'b1;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      ST_START: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // busy is registered from next-cycle occupancy so it lines up with the registered count and state.
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + 1'b1;
    else if (pop && !push) count_nxt = fifo_count - 1'b1;
    busy_nxt = (count_nxt != '0) || (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      en          <= 1'b0;
      we          <= 1'b0;
      start_dec   <= 1'b0;
      addr        <= '0;
      din         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      en          <= en_nxt;
      we          <= we_nxt;
      start_dec   <= start_nxt;
      addr        <= addr_nxt;
      din         <= din_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
